// File: rtl/dev_reshuffler_core.sv
// Block reshuffler: buffers one Dim x Dim block of rows, then re-emits it row by row, straight or transposed.
// Latency: first output row is valid the cycle after the Dim-th input row is accepted.
// Backpressure: input is refused for the whole drain phase; output rows hold stable until out_ready_i.
module dev_reshuffler_core #(
  parameter int DataWidth = 8,
  parameter int Dim       = 8,
  parameter int RowWidth  = Dim * DataWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_transpose_i,
  input  logic [RowWidth-1:0] in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [RowWidth-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                block_done_o
);

  localparam int CntW = (Dim > 1) ? $clog2(Dim) : 1;
  localparam logic [CntW-1:0] LastRow = CntW'(Dim - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     row_cnt_q, row_cnt_d;
  logic                xpose_q, xpose_d;
  logic                done_q, done_d;
  logic [RowWidth-1:0] mem_q [Dim];

  logic in_fire;
  logic out_fire;

  // Input is only accepted while filling and never while reset is held.
  assign in_ready_o   = (state_q == FILL) && !rst_i;
  assign out_valid_o  = (state_q == DRAIN);
  assign in_fire      = in_valid_i && in_ready_o;
  assign out_fire     = out_valid_o && out_ready_i;
  assign busy_o       = (state_q == DRAIN) || (row_cnt_q != '0);
  assign block_done_o = done_q;

  // Next-state: row counter walks the block in both phases; transpose mode is captured with row 0.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    xpose_d   = xpose_q;
    done_d    = 1'b0;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          if (row_cnt_q == '0) xpose_d = en_transpose_i;
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = FILL;
            done_d    = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = FILL;
        row_cnt_d = '0;
      end
    endcase
  end

  // Control state register; reset aborts any block in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      row_cnt_q <= '0;
      xpose_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      xpose_q   <= xpose_d;
      done_q    <= done_d;
    end
  end

  // Block buffer: plain storage, contents are don't-care until rewritten.
  always_ff @(posedge clk_i) begin
    if (in_fire) mem_q[row_cnt_q] <= in_data_i;
  end

  // Output row select: a stored row, or column row_cnt gathered across all rows when transposing.
  always_comb begin
    out_data_o = '0;
    if (state_q == DRAIN) begin
      if (xpose_q) begin
        for (int j = 0; j < Dim; j++) begin
          out_data_o[j*DataWidth +: DataWidth] = mem_q[CntW'(j)][row_cnt_q*DataWidth +: DataWidth];
        end
      end else begin
        out_data_o = mem_q[row_cnt_q];
      end
    end
  end

endmodule

// File: tb/tb_dev_reshuffler_core.sv
module tb_dev_reshuffler_core;

  localparam int DW = 8;
  localparam int DIM = 8;
  localparam int RW = DW * DIM;

  typedef logic [RW-1:0] row_t;
  typedef row_t blk_t [DIM];
  typedef logic en_seq_t [DIM];

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    en_transpose = 1'b0;
  row_t    in_data = '0;
  logic    in_valid = 1'b0;
  logic    in_ready;
  row_t    out_data;
  logic    out_valid;
  logic    out_ready = 1'b0;
  logic    busy;
  logic    block_done;

  int vecs = 0;
  int miscompares = 0;
  blk_t got;

  always #5 clk = ~clk;

  dev_reshuffler_core #(.DataWidth(DW), .Dim(DIM)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_transpose_i(en_transpose),
    .in_data_i(in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .out_data_o(out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .busy_o(busy),
    .block_done_o(block_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: output row k is input row k, or column k of the block when transposing.
  function automatic blk_t model(input blk_t rows, input logic t);
    blk_t e;
    for (int k = 0; k < DIM; k++) begin
      if (t) begin
        e[k] = '0;
        for (int j = 0; j < DIM; j++) e[k][j*DW +: DW] = rows[j][k*DW +: DW];
      end else begin
        e[k] = rows[k];
      end
    end
    return e;
  endfunction

  function automatic blk_t counting_block();
    blk_t b;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) b[r][c*DW +: DW] = DW'(DIM * r + c);
    return b;
  endfunction

  function automatic blk_t random_block();
    blk_t b;
    for (int r = 0; r < DIM; r++) b[r] = {$urandom, $urandom};
    return b;
  endfunction

  function automatic en_seq_t const_en(input logic v);
    en_seq_t s;
    for (int r = 0; r < DIM; r++) s[r] = v;
    return s;
  endfunction

  // Feed one block, drain it with optional random stalls, and check everything on the way.
  task automatic run_block(input blk_t rows, input en_seq_t en_seq, input int stall_pct, input bit hold);
    blk_t exp;
    int   k;
    int   cyc;
    logic was_rdy;
    exp = model(rows, en_seq[0]);
    for (int r = 0; r < DIM; r++) begin
      in_valid     = 1'b1;
      in_data      = rows[r];
      en_transpose = en_seq[r];
      out_ready    = 1'($urandom_range(1));
      vecs++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_row%0d: in_ready=%b out_valid=%b, want 1/0", r, in_ready, out_valid);
      end
      if (r > 0) begin
        vecs++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL fill_busy row%0d: busy=%b, want 1", r, busy);
        end
      end
      tick();
    end
    in_valid     = hold;
    in_data      = {$urandom, $urandom};
    en_transpose = 1'($urandom_range(1));
    k = 0;
    cyc = 0;
    while (k < DIM && cyc < 200) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (hold) in_data = {$urandom, $urandom};
      vecs++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        miscompares++;
        $display("FAIL drain_row%0d: valid=%b data=%h, want 1 %h", k, out_valid, out_data, exp[k]);
      end
      vecs++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || block_done !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_ctrl row%0d: in_ready=%b busy=%b done=%b, want 0 1 0", k, in_ready, busy, block_done);
      end
      got[k] = out_data;
      was_rdy = out_ready;
      tick();
      if (was_rdy) k++;
      cyc++;
    end
    if (k < DIM) begin
      miscompares++;
      $display("FAIL drain_timeout: emitted %0d rows, want %0d", k, DIM);
    end
    out_ready = 1'($urandom_range(1));
    vecs++;
    if (block_done !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL block_end: done=%b valid=%b data=%h in_ready=%b busy=%b, want 1 0 0 1 0",
               block_done, out_valid, out_data, in_ready, busy);
    end
    if (!hold) begin
      in_valid = 1'b0;
      tick();
      vecs++;
      if (block_done !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse_width: done=%b valid=%b, want 0 0", block_done, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    vecs++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_held: in_ready=%b, want 0", in_ready);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || block_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: in_ready=%b valid=%b data=%h busy=%b done=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_data, busy, block_done);
    end
  endtask

  task automatic test_passthrough();
    run_block(counting_block(), const_en(1'b0), 0, 1'b0);
    vecs++;
    if (got[0] !== 64'h0706050403020100 || got[7] !== 64'h3F3E3D3C3B3A3938) begin
      miscompares++;
      $display("FAIL passthrough_literal: row0=%h row7=%h, want 0706050403020100 3f3e3d3c3b3a3938", got[0], got[7]);
    end
  endtask

  task automatic test_transpose();
    run_block(counting_block(), const_en(1'b1), 0, 1'b0);
    vecs++;
    if (got[0] !== 64'h3830282018100800 || got[7] !== 64'h3F372F271F170F07) begin
      miscompares++;
      $display("FAIL transpose_literal: row0=%h row7=%h, want 3830282018100800 3f372f271f170f07", got[0], got[7]);
    end
  endtask

  task automatic test_en_toggle();
    en_seq_t s;
    s = const_en(1'b1);
    for (int r = 3; r < DIM; r++) s[r] = 1'b0;
    run_block(random_block(), s, 0, 1'b0);
    run_block(random_block(), const_en(1'b0), 0, 1'b0);
  endtask

  task automatic test_stall();
    run_block(random_block(), const_en(1'b0), 50, 1'b0);
    run_block(random_block(), const_en(1'b1), 50, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_block(random_block(), const_en(1'b1), 0, 1'b1);
    run_block(random_block(), const_en(1'b0), 30, 1'b1);
    run_block(random_block(), const_en(1'b1), 0, 1'b0);
  endtask

  task automatic test_reset_midblock();
    blk_t junk;
    junk = random_block();
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1;
      in_data = junk[r];
      en_transpose = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    vecs++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_busy: busy=%b, want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vecs++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || block_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: valid=%b busy=%b in_ready=%b done=%b, want 0 0 1 0",
               out_valid, busy, in_ready, block_done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (out_valid !== 1'b0 || block_done !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_idle cyc%0d: valid=%b done=%b, want 0 0", i, out_valid, block_done);
      end
    end
    run_block(random_block(), const_en(1'b0), 20, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      en_seq_t s;
      for (int r = 0; r < DIM; r++) s[r] = 1'($urandom_range(1));
      run_block(random_block(), s, $urandom_range(70), 1'($urandom_range(1)));
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_transpose();
    test_en_toggle();
    test_stall();
    test_back_to_back();
    test_reset_midblock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/dev_reshuffler_core.md
Name: dev_reshuffler_core

Overview:
- Data-path stage directly downstream of the reshuffler CSR file; consumes its 1-bit transpose-enable configuration.
- Accepts a stream of Dim-element rows and buffers one full Dim x Dim block.
- Re-emits the block row by row, either unchanged or transposed.
- Single-buffered; fill and drain phases never overlap.

Parameters:
- DataWidth, 8: bits per element.
- Dim, 8: matrix dimension (rows per block, elements per row); must be >= 2.
- RowWidth, Dim*DataWidth: bits per stream beat (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset.
- en_transpose_i  in  1  transpose enable, driven by the CSR file's transpose-enable output.
- in_data_i  in  RowWidth  input row; element j occupies bits [j*DataWidth +: DataWidth].
- in_valid_i  in  1  input row valid.
- in_ready_o  out  1  core can accept an input row.
- out_data_o  out  RowWidth  output row; same element packing as input.
- out_valid_o  out  1  output row valid.
- out_ready_i  in  1  downstream accepts the output row.
- busy_o  out  1  high whenever a block is partially filled or draining.
- block_done_o  out  1  one-cycle pulse on the handshake of the last output row.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst_i high at a clock edge) sets: state FILL, row_cnt 0, latched transpose flag 0, block_done_o 0.
- Buffer contents are not reset.
- While rst_i is high, in_ready_o is forced 0.
- Output values after reset: in_ready_o 1, out_valid_o 0, out_data_o 0, busy_o 0, block_done_o 0.
- Handshake: a transfer occurs on a cycle where valid && ready is high at the rising edge.
- Once asserted, out_valid_o stays high and out_data_o stays stable until the transfer occurs.
- row_cnt is $clog2(Dim) bits wide.
- FSM state FILL:
  - in_ready_o = 1, out_valid_o = 0.
  - On an input transfer, row in_data_i is written to buffer row row_cnt.
  - On the transfer with row_cnt == 0, en_transpose_i is latched into the transpose flag.
  - The transfer with row_cnt == Dim-1 sets row_cnt to 0 and moves to DRAIN; otherwise row_cnt increments.
- FSM state DRAIN:
  - in_ready_o = 0, out_valid_o = 1.
  - out_data_o is combinational from the buffer and row_cnt:
    - transpose flag = 0: out element j = buffer[row_cnt][j].
    - transpose flag = 1: out element j = buffer[j][row_cnt].
  - On an output transfer with row_cnt == Dim-1: row_cnt = 0, go to FILL, block_done_o = 1 next cycle. Otherwise row_cnt increments.
- out_data_o is driven to 0 whenever out_valid_o = 0.
- busy_o = (state == DRAIN) || (row_cnt != 0).
- Latency: out_valid_o rises in the cycle after the Dim-th input transfer. The first input of the next block can be accepted in the cycle after the final output transfer.
- Max throughput: Dim rows in plus Dim rows out per 2*Dim cycles.
- Changes on en_transpose_i after the first row of a block is accepted have no effect until the next block.
- in_valid_i asserted during DRAIN is ignored (no transfer, not stored).
- out_ready_i has no effect outside DRAIN.
- Reset asserted mid-FILL or mid-DRAIN aborts the block:
  - Partial data is discarded and no block_done_o pulse is issued.
  - The next accepted row is treated as row 0.
- No arithmetic on element values; elements are only relocated.

Test Plan:
- Dim=8, DataWidth=8, en_transpose_i=0, in row r element c = 8r+c, out_ready_i tied 1 -> out rows equal input rows (row 0 = 0x0706050403020100, MSB first); block_done_o pulses once, 1 cycle after the 8th output transfer.
- Same stimulus with en_transpose_i=1 -> out row k element j = 8j+k; row 0 = 0x3830282018100800; row 7 = 0x3F372F271F170F07.
- en_transpose_i=1 at row 0, toggled to 0 at row 3 -> entire block still transposed; next block (en=0 at row 0) passes straight through.
- Random out_ready_i stalls (~50%) during DRAIN -> out_data_o/out_valid_o held stable while stalled; all 8 rows emitted in order; in_ready_o stays 0 until the final output transfer.
- in_valid_i held high continuously -> in_ready_o low for the 8 drain cycles; no extra rows are stored; the next block begins correctly with row 0.
- rst_i pulsed after 5 input rows -> out_valid_o stays 0, busy_o 0 and in_ready_o 1 after reset, no block_done_o; the following 8 rows form a correct block.
